// File: rtl/ptable_walker_pkg.sv
// ptable_walker_pkg: shared types for the page-table-walker translation-buffer retire path
package ptable_walker_pkg;
   localparam int NENT = 16;
   localparam logic [5:0] SEG_MQNDX = 6'd16;
   localparam logic [5:0] PTW_NO_SEL = 6'h20;
   typedef logic [63:0] virtual_address_t;
   typedef logic [15:0] asid_t;
   typedef logic [63:0] ptw_pte_t;
   typedef enum logic [1:0] {INACTIVE, TLB_PTE_FETCH, SEG_BASE_FETCH, SEG_LIMIT_FETCH} ptw_access_t;
   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} ptw_retire_state_t;
   typedef struct packed {
      logic pte_size;
      logic [2:0] levels;
   } ptattr_t;
   typedef struct packed {
      logic v;
      logic rdy;
      ptw_access_t access_state;
      logic [5:0] mqndx;
      asid_t asid;
      virtual_address_t vadr;
      logic [63:0] padr;
      ptw_pte_t pte;
      logic [255:0] dat;
   } ptw_tran_buf_t;
   // pte_size=0 means 32-bit PTEs; the upper word is not part of the entry
   function automatic ptw_pte_t pte_fit(ptw_pte_t p, logic sz);
      return sz ? p : {32'b0, p[31:0]};
   endfunction
endpackage

// File: rtl/ptw_rr_find16.sv
// ptw_rr_find16: combinational round-robin finder, first set req bit at or after start (wrapping)
module ptw_rr_find16 (
   input  logic [15:0] req,
   input  logic [3:0]  start,
   output logic        found,
   output logic [3:0]  idx
);
   assign found = |req;
   // walk offsets downward so the smallest offset from start wins
   always_comb begin
      idx = start;
      for (int k = 15; k >= 0; k--)
         if (req[4'(start + 4'(k))]) idx = 4'(start + 4'(k));
   end
endmodule

// File: rtl/ptw_tran_retire.sv
// ptw_tran_retire: retires ready tranbuf entries to the TLB, segment regs or fault path, then frees them
// Optional PTW_RETIRE_STATS_EN adds saturating stat_tlb_wr / stat_fault counters.
module ptw_tran_retire import ptable_walker_pkg::*; (
   input  logic                  clk,
   input  logic                  rst,
   input  ptattr_t               ptattr,
   input  ptw_tran_buf_t [15:0]  tranbuf,
   input  logic                  flush,
   output logic [5:0]            sel_tran,
   output logic                  tlb_wr,
   input  logic                  tlb_wr_ack,
   output virtual_address_t      tlb_vadr,
   output asid_t                 tlb_asid,
   output ptw_pte_t              tlb_pte,
   output logic                  seg_wr,
   output logic                  seg_limit,
   output logic [63:0]           seg_dat,
   output logic                  fault,
   output virtual_address_t      fault_vadr,
   output logic                  mq_done,
   output logic [4:0]            mq_ndx
`ifdef PTW_RETIRE_STATS_EN
   ,
   output logic [31:0]           stat_tlb_wr,
   output logic [31:0]           stat_fault
`endif
);
   ptw_retire_state_t st;
   logic [3:0] rr_ptr, idx, l_idx;
   logic [5:0] l_mq;
   logic [15:0] req;
   logic [255:0] sh;
   logic found, go_issue, is_seg;
   ptw_tran_buf_t ent;
   logic unused_ok;
   // entry 0 is never a candidate: tid 0 is invalid
   always_comb begin
      req = '0;
      for (int k = 1; k < NENT; k++) req[k] = tranbuf[k].v & tranbuf[k].rdy;
   end
   ptw_rr_find16 u_find (.req(req), .start(rr_ptr), .found(found), .idx(idx));
   assign ent = tranbuf[idx];
   assign sh = ent.dat >> {ent.padr[4:3], 6'b0};
   assign go_issue = ent.access_state == TLB_PTE_FETCH && ent.pte[0];
   assign is_seg = ent.access_state == SEG_BASE_FETCH || ent.access_state == SEG_LIMIT_FETCH;
   assign unused_ok = ^{ent.v, ent.rdy, ent.padr[63:5], ent.padr[2:0], ptattr.levels};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st <= IDLE;
         rr_ptr <= 4'd1;
         sel_tran <= PTW_NO_SEL;
         tlb_wr <= 1'b0;
         seg_wr <= 1'b0;
         fault <= 1'b0;
         mq_done <= 1'b0;
         tlb_vadr <= '0;
         tlb_asid <= '0;
         tlb_pte <= '0;
         seg_limit <= 1'b0;
         seg_dat <= '0;
         fault_vadr <= '0;
         mq_ndx <= '0;
         l_idx <= '0;
         l_mq <= '0;
      end else begin
         sel_tran <= PTW_NO_SEL;
         seg_wr <= 1'b0;
         fault <= 1'b0;
         mq_done <= 1'b0;
         case (st)
            IDLE:
               if (found) begin
                  l_idx <= idx;
                  l_mq <= ent.mqndx;
                  rr_ptr <= (idx == 4'd15) ? 4'd1 : idx + 4'd1;
                  tlb_vadr <= ent.vadr;
                  tlb_asid <= ent.asid;
                  tlb_pte <= pte_fit(ent.pte, ptattr.pte_size);
                  fault_vadr <= ent.vadr;
                  seg_dat <= sh[63:0];
                  seg_limit <= ent.access_state == SEG_LIMIT_FETCH;
                  mq_ndx <= ent.mqndx[4:0];
                  if (go_issue) begin
                     st <= ISSUE;
                     tlb_wr <= 1'b1;
                  end else begin
                     st <= RELEASE;
                     sel_tran <= {2'b00, idx};
                     mq_done <= !flush && ent.access_state != INACTIVE && ent.mqndx != SEG_MQNDX;
                     seg_wr <= !flush && is_seg;
                     fault <= !flush && ent.access_state == TLB_PTE_FETCH;
                  end
               end
            ISSUE:
               if (flush || tlb_wr_ack) begin
                  st <= RELEASE;
                  tlb_wr <= 1'b0;
                  sel_tran <= {2'b00, l_idx};
                  mq_done <= !flush && l_mq != SEG_MQNDX;
               end
            default: st <= IDLE;
         endcase
      end
`ifdef PTW_RETIRE_STATS_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         stat_tlb_wr <= '0;
         stat_fault <= '0;
      end else begin
         if (st == ISSUE && tlb_wr_ack && !flush && !(&stat_tlb_wr)) stat_tlb_wr <= stat_tlb_wr + 32'd1;
         if (fault && !(&stat_fault)) stat_fault <= stat_fault + 32'd1;
      end
`endif
endmodule

// File: tb/tb_ptw_tran_retire.sv
// tb_ptw_tran_retire: scoreboard bench for ptw_tran_retire with a batch-level round-robin reference model
module tb_ptw_tran_retire;
   import ptable_walker_pkg::*;
   logic clk = 0, rst = 0, flush = 0, tlb_wr_ack = 0;
   ptattr_t ptattr;
   ptw_tran_buf_t [15:0] tranbuf;
   logic [5:0] sel_tran;
   logic tlb_wr, seg_wr, seg_limit, fault, mq_done;
   virtual_address_t tlb_vadr, fault_vadr;
   asid_t tlb_asid;
   ptw_pte_t tlb_pte;
   logic [63:0] seg_dat;
   logic [4:0] mq_ndx;
`ifdef PTW_RETIRE_STATS_EN
   logic [31:0] stat_tlb_wr, stat_fault;
`endif

   ptw_tran_retire dut (
      .clk(clk), .rst(rst), .ptattr(ptattr), .tranbuf(tranbuf), .flush(flush),
      .sel_tran(sel_tran), .tlb_wr(tlb_wr), .tlb_wr_ack(tlb_wr_ack),
      .tlb_vadr(tlb_vadr), .tlb_asid(tlb_asid), .tlb_pte(tlb_pte),
      .seg_wr(seg_wr), .seg_limit(seg_limit), .seg_dat(seg_dat),
      .fault(fault), .fault_vadr(fault_vadr), .mq_done(mq_done), .mq_ndx(mq_ndx)
`ifdef PTW_RETIRE_STATS_EN
      , .stat_tlb_wr(stat_tlb_wr), .stat_fault(stat_fault)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      bit tlb, mq_done, seg_wr, fault, seg_limit;
      bit [4:0] mq_ndx;
      bit [63:0] seg_dat, fault_vadr, tv, tp;
      bit [15:0] ta;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int checks = 0, failures = 0;
   int mptr = 1, force_lat = 0, cur_lat = 1, cnt = 0, hi = 0, since_ack = 100;
   int overlap = 0, stray = 0, exp_ack = 0, exp_fault = 0;
   bit acked = 0;
   logic [63:0] cv, cp;
   logic [15:0] ca;

   task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", n, got, exp);
      end
   endtask

   // expected outcome of retiring one entry, straight from the retire rules
   function automatic exp_t model(int i, ptw_tran_buf_t e, bit sz, bit fl);
      exp_t r;
      bit is_pte = e.access_state == TLB_PTE_FETCH;
      bit is_seg = e.access_state == SEG_BASE_FETCH || e.access_state == SEG_LIMIT_FETCH;
      r = '{default: 0};
      r.idx = i;
      if (!fl) begin
         r.tlb = is_pte && e.pte[0];
         r.fault = is_pte && !e.pte[0];
         r.seg_wr = is_seg;
         r.mq_done = e.access_state != INACTIVE && e.mqndx != 6'd16;
      end
      r.seg_limit = e.access_state == SEG_LIMIT_FETCH;
      r.seg_dat = e.dat[64 * int'(e.padr[4:3]) +: 64];
      r.mq_ndx = 5'(e.mqndx % 32);
      r.fault_vadr = e.vadr;
      r.tv = e.vadr;
      r.ta = e.asid;
      r.tp = sz ? e.pte : e.pte % 64'h1_0000_0000;
      return r;
   endfunction

   // ack responder: holds off for cur_lat cycles of tlb_wr, otherwise throws stray acks
   always @(posedge clk) begin
      #1;
      if (tlb_wr) begin
         cnt++;
         if (cnt == 1) cur_lat = force_lat != 0 ? force_lat : int'($urandom_range(1, 4));
         tlb_wr_ack = cnt >= cur_lat;
      end else begin
         cnt = 0;
         tlb_wr_ack = $urandom_range(0, 3) == 0;
      end
   end

   // monitor: pops the scoreboard on every freed entry
   always @(negedge clk) if (!rst) begin
      since_ack++;
      if (tlb_wr && !sel_tran[5]) overlap++;
      if (sel_tran[5] && (mq_done || seg_wr || fault)) stray++;
      if (tlb_wr) begin
         hi++;
         if (tlb_wr_ack) begin
            chk("tlb_wr_hold", 64'(hi), 64'(cur_lat));
            acked = 1;
            since_ack = 0;
            cv = tlb_vadr; ca = tlb_asid; cp = tlb_pte;
            exp_ack++;
         end
      end else hi = 0;
      if (!sel_tran[5]) begin
         if (q.size() == 0) chk("unexpected_release", 64'(sel_tran), 64'h20);
         else begin
            me = q.pop_front();
            chk("sel_tran", 64'(sel_tran), 64'(me.idx));
            chk("pulses_tlb_mq_seg_fault", 64'({acked, mq_done, seg_wr, fault}),
                64'({me.tlb, me.mq_done, me.seg_wr, me.fault}));
            if (me.mq_done) chk("mq_ndx", 64'(mq_ndx), 64'(me.mq_ndx));
            if (me.seg_wr) begin
               chk("seg_limit", 64'(seg_limit), 64'(me.seg_limit));
               chk("seg_dat", seg_dat, me.seg_dat);
            end
            if (me.fault) begin
               chk("fault_vadr", fault_vadr, me.fault_vadr);
               exp_fault++;
            end
            if (me.tlb) begin
               chk("tlb_vadr", cv, me.tv);
               chk("tlb_asid", 64'(ca), 64'(me.ta));
               chk("tlb_pte", cp, me.tp);
               chk("ack_to_release", 64'(since_ack), 64'd1);
            end
         end
         acked = 0;
      end
   end

   task automatic tick();
      @(negedge clk);
      if (!sel_tran[5]) tranbuf[sel_tran[3:0]].v = 1'b0;
   endtask

   task automatic mk(int i, int kind, bit vb, int mq);
      logic [63:0] p;
      p = {$urandom, $urandom};
      p[0] = vb;
      tranbuf[i].v = 1'b1;
      tranbuf[i].rdy = 1'b1;
      tranbuf[i].access_state = ptw_access_t'(kind[1:0]);
      tranbuf[i].mqndx = mq[5:0];
      tranbuf[i].asid = 16'($urandom);
      tranbuf[i].vadr = {$urandom, $urandom};
      tranbuf[i].padr = {$urandom, $urandom};
      tranbuf[i].pte = p;
      tranbuf[i].dat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   // a batch loaded at once retires in cyclic index order starting at the pointer
   task automatic commit(bit fl);
      int p = mptr;
      for (int k = 0; k < 15; k++) begin
         int i = (p - 1 + k) % 15 + 1;
         if (tranbuf[i].v && tranbuf[i].rdy) begin
            q.push_back(model(i, tranbuf[i], ptattr.pte_size, fl));
            mptr = i % 15 + 1;
         end
      end
   endtask

   function automatic bit busy();
      for (int i = 1; i < 16; i++) if (tranbuf[i].v && tranbuf[i].rdy) return 1;
      return 0;
   endfunction

   task automatic drain();
      int n = 0;
      if (!sel_tran[5]) tranbuf[sel_tran[3:0]].v = 1'b0;
      while (n < 300 && (busy() || q.size() != 0)) begin
         tick();
         n++;
      end
      chk("drain_timeout", 64'(n < 300), 64'd1);
      tick();
      tick();
      for (int i = 1; i < 16; i++) tranbuf[i].v = 1'b0;
   endtask

   task automatic wait_tlb_wr();
      int n = 0;
      while (n < 40 && !tlb_wr) begin
         tick();
         n++;
      end
      chk("tlb_wr_seen", 64'(tlb_wr), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      tranbuf = '0;
      ptattr = '0;
      ptattr.pte_size = 1'b1;
      mk(0, 1, 1, 3);
      #1 rst = 1;
      repeat (2) @(negedge clk);
      chk("rst_sel_tran", 64'(sel_tran), 64'h20);
      chk("rst_pulses", 64'({tlb_wr, mq_done, seg_wr, fault}), 64'd0);
      chk("rst_data", tlb_vadr | tlb_pte | seg_dat | fault_vadr, 64'd0);
      rst = 0;
      tick();

      force_lat = 3;
      mk(5, 1, 1, 7);
      commit(0);
      drain();
      force_lat = 0;

      mk(9, 1, 0, 2);
      commit(0);
      drain();
      mk(3, 1, 1, 3);
      mk(9, 2, 0, 16);
      mk(14, 1, 1, 5);
      commit(0);
      drain();

      mk(2, 3, 0, 16);
      tranbuf[2].padr[4:3] = 2'd2;
      commit(0);
      drain();

      mk(7, 1, 0, 9);
      commit(0);
      drain();

      force_lat = 50;
      mk(6, 1, 1, 4);
      commit(1);
      wait_tlb_wr();
      flush = 1;
      tick();
      flush = 0;
      chk("flush_drops_tlb_wr", 64'(tlb_wr), 64'd0);
      drain();
      force_lat = 0;

      for (int b = 0; b < 40; b++) begin
         ptattr.pte_size = 1'($urandom);
         for (int i = 1; i < 16; i++) begin
            int r = $urandom_range(0, 3);
            if (r < 2)
               mk(i, $urandom_range(0, 3), 1'($urandom),
                  $urandom_range(0, 3) == 0 ? 16 : $urandom_range(0, 40));
            else if (r == 2) begin
               mk(i, 1, 1, 1);
               tranbuf[i].rdy = 1'b0;
            end
         end
         commit(0);
         drain();
      end

`ifdef PTW_RETIRE_STATS_EN
      chk("stat_tlb_wr", 64'(stat_tlb_wr), 64'(exp_ack));
      chk("stat_fault", 64'(stat_fault), 64'(exp_fault));
`endif

      ptattr.pte_size = 1'b1;
      force_lat = 50;
      mk(4, 1, 1, 1);
      wait_tlb_wr();
      tick();
      #2 rst = 1;
      #1;
      chk("async_rst_tlb_wr", 64'(tlb_wr), 64'd0);
      chk("async_rst_sel_tran", 64'(sel_tran), 64'h20);
      chk("async_rst_data", tlb_vadr | tlb_pte | 64'(tlb_asid), 64'd0);
`ifdef PTW_RETIRE_STATS_EN
      chk("async_rst_stats", 64'({stat_tlb_wr, stat_fault}), 64'd0);
`endif
      for (int i = 1; i < 16; i++) tranbuf[i].v = 1'b0;
      q.delete();
      hi = 0;
      acked = 0;
      mptr = 1;
      exp_ack = 0;
      exp_fault = 0;
      repeat (2) tick();
      rst = 0;
      force_lat = 0;

      mk(2, 1, 1, 3);
      mk(14, 1, 0, 5);
      commit(0);
      drain();
`ifdef PTW_RETIRE_STATS_EN
      chk("stat_tlb_wr_after_rst", 64'(stat_tlb_wr), 64'd1);
      chk("stat_fault_after_rst", 64'(stat_fault), 64'd1);
`endif

      chk("tlb_wr_overlaps_sel_tran", 64'(overlap), 64'd0);
      chk("stray_pulses", 64'(stray), 64'd0);
      chk("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
